// File: rtl/z_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : z_read_scheduler
// Purpose  : Z-test front-end sequencer. Accepts pixel pairs from the
//            rasterizer, issues one Z read per pair on the shared 64-bit
//            Avalon-MM SDRAM port and enqueues the pair into the read FIFO
//            once the read is accepted. Arbitrates the same port between Z
//            reads and write-backs from the write FIFO (round robin on ties).
//            Reads are throttled on read-FIFO occupancy and on the number of
//            reads in flight, so the read FIFO can never overflow.
// Ports    : clock, reset          - clock, async active-high reset
//            z_active              - Z test enabled (low: pairs bypass memory)
//            px_*                  - pixel pair handshake and payload
//            fifo_size             - read FIFO usedw
//            fifo_*                - read FIFO enqueue strobe and payload
//            wr_*                  - write-back request handshake and payload
//            mem_*                 - Avalon-MM master
//            outstanding           - Z reads accepted but not yet returned
//            stat_reads/writes/stalls (optional) - wrapping event counters
// Options  : define Z_READ_SCHED_STATS_EN to add the statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module z_read_scheduler #(
  parameter int FIFO_DEPTH      = 32,
  parameter int FIFO_DEPTH_LOG2 = 5,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             z_active,
  input  logic                             px_valid,
  output logic                             px_ready,
  input  logic [28:0]                      px_color_address,
  input  logic [28:0]                      px_z_address,
  input  logic [63:0]                      px_color,
  input  logic [63:0]                      px_z,
  input  logic [1:0]                       px_pixel_active,
  input  logic [FIFO_DEPTH_LOG2-1:0]       fifo_size,
  output logic                             fifo_enqueue,
  output logic [28:0]                      fifo_color_address,
  output logic [28:0]                      fifo_z_address,
  output logic [63:0]                      fifo_color,
  output logic [63:0]                      fifo_z,
  output logic [1:0]                       fifo_pixel_active,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [28:0]                      wr_address,
  input  logic [63:0]                      wr_data,
  input  logic [7:0]                       wr_byteenable,
  output logic [28:0]                      mem_address,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [63:0]                      mem_writedata,
  output logic [7:0]                       mem_byteenable,
  input  logic                             mem_waitrequest,
  input  logic                             mem_readdatavalid,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding
`ifdef Z_READ_SCHED_STATS_EN
  ,
  output logic [31:0]                      stat_reads,
  output logic [31:0]                      stat_writes,
  output logic [31:0]                      stat_stalls
`endif
);

  localparam int c_OUT_W = $clog2(MAX_OUTSTANDING) + 1;

  // Two enqueues may be in flight but not yet visible in fifo_size, plus
  // one slot of margin, hence the limit of FIFO_DEPTH-3.
  localparam logic [FIFO_DEPTH_LOG2-1:0] c_ROOM_LIMIT = FIFO_DEPTH_LOG2'(FIFO_DEPTH - 3);
  localparam logic [c_OUT_W-1:0]         c_OUT_LIMIT  = c_OUT_W'(MAX_OUTSTANDING);
  localparam logic [c_OUT_W-1:0]         c_OUT_ONE    = c_OUT_W'(1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_READ  = 2'd1;
  localparam logic [1:0] c_WRITE = 2'd2;

  localparam logic c_GRANT_READ  = 1'b0;
  localparam logic c_GRANT_WRITE = 1'b1;

  logic [1:0]         r_state;
  logic               r_last_grant;
  logic               r_bypass_hold;
  logic [c_OUT_W-1:0] r_outstanding;

  logic [28:0]        r_cap_color_address;
  logic [28:0]        r_cap_z_address;
  logic [63:0]        r_cap_color;
  logic [63:0]        r_cap_z;
  logic [1:0]         r_cap_pixel_active;

  logic               r_fifo_enqueue;
  logic [28:0]        r_fifo_color_address;
  logic [28:0]        r_fifo_z_address;
  logic [63:0]        r_fifo_color;
  logic [63:0]        r_fifo_z;
  logic [1:0]         r_fifo_pixel_active;

  logic [28:0]        r_mem_address;
  logic [63:0]        r_mem_writedata;
  logic [7:0]         r_mem_byteenable;

  logic w_room;
  logic w_below_limit;
  logic w_can_read;
  logic w_arb_open;
  logic w_grant_read;
  logic w_grant_write;
  logic w_zread_grant;
  logic w_bypass_grant;
  logic w_read_accept;
  logic w_write_done;
  logic w_return;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  assign w_room        = (fifo_size < c_ROOM_LIMIT);
  assign w_below_limit = (r_outstanding < c_OUT_LIMIT);
  assign w_can_read    = px_valid & w_room & (~z_active | w_below_limit);

  // A bypass grant finishes in IDLE, so the following cycle is blocked to
  // keep the mandatory gap between grants. Grants are masked during reset
  // so the handshakes read 0 while the block is held in reset.
  assign w_arb_open    = (r_state == c_IDLE) & ~r_bypass_hold & ~reset;

  // On a tie the side that did not win last time gets the port.
  assign w_grant_read  = w_arb_open & w_can_read &
                         (~wr_valid | (r_last_grant == c_GRANT_WRITE));
  assign w_grant_write = w_arb_open & wr_valid &
                         ~(w_can_read & (r_last_grant == c_GRANT_WRITE));

  assign w_zread_grant  = w_grant_read & z_active;
  assign w_bypass_grant = w_grant_read & ~z_active;

  assign w_read_accept = (r_state == c_READ)  & ~mem_waitrequest;
  assign w_write_done  = (r_state == c_WRITE) & ~mem_waitrequest;

  // A return with nothing counted (e.g. data for a read dropped by reset)
  // is ignored so the counter never underflows.
  assign w_return      = mem_readdatavalid & (r_outstanding != '0);

  assign px_ready = w_grant_read;
  assign wr_ready = w_grant_write;

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_zread_grant) begin
            r_state <= c_READ;
          end else if (w_grant_write) begin
            r_state <= c_WRITE;
          end
        end
        c_READ: begin
          if (w_read_accept) begin
            r_state <= c_IDLE;
          end
        end
        c_WRITE: begin
          if (w_write_done) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Capture, FIFO output and memory command registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_grant         <= c_GRANT_WRITE;
      r_bypass_hold        <= 1'b0;
      r_outstanding        <= '0;
      r_cap_color_address  <= '0;
      r_cap_z_address      <= '0;
      r_cap_color          <= '0;
      r_cap_z              <= '0;
      r_cap_pixel_active   <= '0;
      r_fifo_enqueue       <= 1'b0;
      r_fifo_color_address <= '0;
      r_fifo_z_address     <= '0;
      r_fifo_color         <= '0;
      r_fifo_z             <= '0;
      r_fifo_pixel_active  <= '0;
      r_mem_address        <= '0;
      r_mem_writedata      <= '0;
      r_mem_byteenable     <= '0;
    end else begin
      r_fifo_enqueue <= w_read_accept | w_bypass_grant;
      r_bypass_hold  <= w_bypass_grant;

      if (w_grant_read | w_grant_write) begin
        r_last_grant <= w_grant_write;
      end

      // The pair waits here while its Z read is on the bus.
      if (w_zread_grant) begin
        r_cap_color_address <= px_color_address;
        r_cap_z_address     <= px_z_address;
        r_cap_color         <= px_color;
        r_cap_z             <= px_z;
        r_cap_pixel_active  <= px_pixel_active;
        r_mem_address       <= px_z_address;
      end

      if (w_grant_write) begin
        r_mem_address    <= wr_address;
        r_mem_writedata  <= wr_data;
        r_mem_byteenable <= wr_byteenable;
      end

      // FIFO payload only changes together with the enqueue strobe, so it
      // is stable whenever fifo_enqueue is low.
      if (w_read_accept) begin
        r_fifo_color_address <= r_cap_color_address;
        r_fifo_z_address     <= r_cap_z_address;
        r_fifo_color         <= r_cap_color;
        r_fifo_z             <= r_cap_z;
        r_fifo_pixel_active  <= r_cap_pixel_active;
      end else if (w_bypass_grant) begin
        r_fifo_color_address <= px_color_address;
        r_fifo_z_address     <= px_z_address;
        r_fifo_color         <= px_color;
        r_fifo_z             <= px_z;
        r_fifo_pixel_active  <= px_pixel_active;
      end

      if (w_read_accept && !w_return) begin
        r_outstanding <= r_outstanding + c_OUT_ONE;
      end else if (!w_read_accept && w_return) begin
        r_outstanding <= r_outstanding - c_OUT_ONE;
      end
    end
  end

  assign fifo_enqueue       = r_fifo_enqueue;
  assign fifo_color_address = r_fifo_color_address;
  assign fifo_z_address     = r_fifo_z_address;
  assign fifo_color         = r_fifo_color;
  assign fifo_z             = r_fifo_z;
  assign fifo_pixel_active  = r_fifo_pixel_active;

  // Commands come straight from the state so an asynchronous reset drops
  // them in the same cycle.
  assign mem_read       = (r_state == c_READ);
  assign mem_write      = (r_state == c_WRITE);
  assign mem_address    = r_mem_address;
  assign mem_writedata  = r_mem_writedata;
  assign mem_byteenable = r_mem_byteenable;
  assign outstanding    = r_outstanding;

  // --------------------------------------------------------------------------
  // Optional statistics
  // --------------------------------------------------------------------------
`ifdef Z_READ_SCHED_STATS_EN
  logic [31:0] r_stat_reads;
  logic [31:0] r_stat_writes;
  logic [31:0] r_stat_stalls;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stat_reads  <= '0;
      r_stat_writes <= '0;
      r_stat_stalls <= '0;
    end else begin
      if (w_read_accept) begin
        r_stat_reads <= r_stat_reads + 32'd1;
      end
      if (w_write_done) begin
        r_stat_writes <= r_stat_writes + 32'd1;
      end
      if (px_valid && !w_room) begin
        r_stat_stalls <= r_stat_stalls + 32'd1;
      end
    end
  end

  assign stat_reads  = r_stat_reads;
  assign stat_writes = r_stat_writes;
  assign stat_stalls = r_stat_stalls;
`endif

endmodule
`default_nettype wire

// File: doc/z_read_scheduler.md
# z_read_scheduler

Sequences the Z-test front end. Accepts pixel pairs from the rasterizer, issues the Z read for each pair on the shared 64-bit SDRAM port, and enqueues the pair into the read FIFO once the memory accepts the read. It also arbitrates that port between Z reads and color/Z write-backs from the write FIFO. Occupancy throttling guarantees the read FIFO never overflows.

## Interface
- FIFO_DEPTH, 32: depth of the downstream read FIFO.
- FIFO_DEPTH_LOG2, 5: width of `fifo_size`.
- MAX_OUTSTANDING, 8: maximum number of Z reads accepted but not yet returned.
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- z_active  in  1  Z test enabled; when low, pairs bypass the memory read.
- px_valid  in  1  upstream pixel pair present.
- px_ready  out  1  pair accepted this cycle (combinational).
- px_color_address, px_z_address  in  29  word addresses.
- px_color, px_z  in  64  pair data.
- px_pixel_active  in  2  bit 0 is the left pixel.
- fifo_size  in  FIFO_DEPTH_LOG2  read FIFO `usedw`.
- fifo_enqueue  out  1  one-cycle enqueue strobe.
- fifo_color_address, fifo_z_address  out  29  registered copies of the pair.
- fifo_color, fifo_z  out  64  registered copies of the pair.
- fifo_pixel_active  out  2  registered copy of the pair.
- wr_valid  in  1  write-back request.
- wr_ready  out  1  write-back request accepted (combinational).
- wr_address  in  29  write-back address.
- wr_data  in  64  write-back data.
- wr_byteenable  in  8  write-back byte enables.
- mem_address  out  29  Avalon-MM master address.
- mem_read, mem_write  out  1  Avalon-MM master commands.
- mem_writedata  out  64  Avalon-MM master write data.
- mem_byteenable  out  8  Avalon-MM master byte enables.
- mem_waitrequest  in  1  Avalon-MM slave stall.
- mem_readdatavalid  in  1  read data return strobe; the data itself goes to the read FIFO path.
- outstanding  out  log2(MAX_OUTSTANDING)+1  reads in flight.

## Operation
- The FSM has three states: IDLE, READ and WRITE.
- room = fifo_size < FIFO_DEPTH-3. No more than 2 enqueues are ever invisible in `fifo_size`, so `usedw` never wraps.
- can_read = px_valid & room & (!z_active | outstanding < MAX_OUTSTANDING).
- In IDLE, with can_read and wr_valid both true, grant the side not granted last. A 1-bit `last_grant` register records the winner; its reset value is write, so the first tie goes to read.
- Read grant: px_ready=1 and the pair is captured.
  - If z_active, go to READ.
  - Otherwise, next cycle fifo_enqueue=1 with the captured pair and stay IDLE.
- READ: mem_read=1 and mem_address=captured z_address, both held stable while mem_waitrequest=1.
  - On mem_waitrequest=0: outstanding+1; fifo_enqueue=1 next cycle; go to IDLE.
- Write grant: wr_ready=1; capture address, data and byteenable; go to WRITE.
- WRITE: mem_write=1 with the captured fields held stable until mem_waitrequest=0, then go to IDLE.
- outstanding decrements on mem_readdatavalid. If an accept and a return coincide, it is unchanged. It never goes below 0; a return at 0 is ignored.
- mem_read and mem_write are never both 1.
- Only one command is in flight per grant. The IDLE cycle between grants is mandatory.
- z_active is sampled at grant only. A change during READ does not abort the read.

## Timing
- Reset values: state=IDLE. fifo_enqueue, mem_read, mem_write, px_ready, wr_ready and outstanding are all 0. last_grant=write. All data and address outputs are 0.
- Reset mid-READ or mid-WRITE drops the command immediately. The captured pair is lost and no enqueue occurs.
- Z-read pair: accept at N, mem_read at N+1. With no wait, fifo_enqueue at N+2. Each mem_waitrequest cycle adds one.
- Bypass pair: accept at N, fifo_enqueue at N+1. Maximum rate is one pair per 2 cycles for bypass and one per 2 cycles for Z reads with no wait.
- Write: accept at N, mem_write at N+1, IDLE again the cycle after mem_waitrequest=0.
- fifo_enqueue is a single-cycle pulse per accepted pair. Outputs stay stable while it is low.

## Configuration
- Z_READ_SCHED_STATS_EN defined: adds outputs stat_reads, stat_writes and stat_stalls, each 32 bits and wrapping.
  - stat_reads counts accepted reads.
  - stat_writes counts accepted writes.
  - stat_stalls counts cycles where px_valid=1 and room=0.
  - All three clear on reset.
- Undefined: these ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Z read: z_active=1, one pair with z_address=0x100, no wait → mem_read at N+1 with address 0x100; fifo_enqueue at N+2 with fields matching the input; outstanding goes 0→1, then back to 0 on readdatavalid.
- Waitrequest: mem_waitrequest high for 3 cycles → address held constant; enqueue exactly 1 cycle after release.
- Tie: px_valid and wr_valid both continuously asserted after reset → grants alternate read, write, read, write; mem_read and mem_write are never both 1.
- Throttle: fifo_size=29 (FIFO_DEPTH=32) → px_ready=0 while writes still proceed; fifo_size=28 → accepted.
- Outstanding: readdatavalid withheld, 9 pairs offered → exactly 8 reads issued; one return → 9th read issued; bypass pairs (z_active=0) still accepted at the limit.
- Reset asserted during READ with mem_waitrequest=1 → mem_read=0 the same cycle; no fifo_enqueue; outstanding=0; a late readdatavalid leaves outstanding at 0.
